// File: rtl/an_code_pkg.sv
// an_code_pkg: AN-code constants and encoder state type, shared by the encoder, decoder and benches.
package an_code_pkg;
    localparam int A     = 29;
    localparam int A_W   = 5;
    localparam int N_W   = 23;
    localparam int AN_W  = N_W + A_W;
    localparam int CNT_W = $clog2(N_W);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/an_encoder_seq_if.sv
// an_encoder_seq_if: input/output valid-ready handshakes of the AN encoder.
interface an_encoder_seq_if;
    import an_code_pkg::*;
    logic            in_valid;
    logic            in_ready;
    logic [N_W-1:0]  in_n;
    logic            out_valid;
    logic            out_ready;
    logic [AN_W-1:0] out_an;
    logic            out_res_err;
    logic            busy;
    modport slave  (input in_valid, in_n, out_ready, output in_ready, out_valid, out_an, out_res_err, busy);
    modport master (output in_valid, in_n, out_ready, input in_ready, out_valid, out_an, out_res_err, busy);
endinterface

// File: rtl/an_encoder_seq_residue.sv
// an_residue_mod: combinational residue of an AN_W-bit word modulo A.
module an_residue_mod
    import an_code_pkg::*;
(
    input  logic [AN_W-1:0] v,
    output logic [A_W-1:0]  r
);
    assign r = A_W'(v % AN_W'(A));
endmodule

// File: rtl/an_encoder_seq.sv
// an_encoder_seq: bit-serial shift-add AN encoder (out_an = in_n * A) with residue self-check.
module an_encoder_seq
    import an_code_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    an_encoder_seq_if.slave  bus
);
    state_t            state, state_nxt;
    logic [N_W-1:0]    sh;
    logic [AN_W-1:0]   acc, acc_nxt, an_q;
    logic [CNT_W-1:0]  cnt;
    logic [A_W-1:0]    res;
    logic              err_q, last;
    assign last          = cnt == CNT_W'(N_W - 1);
    assign bus.in_ready  = rst_n && state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state == BUSY;
    assign bus.out_an    = an_q;
    assign bus.out_res_err = err_q;
    always_comb begin
        acc_nxt   = acc + (sh[0] ? AN_W'(A) << cnt : '0);
        state_nxt = state == IDLE ? (bus.in_valid ? BUSY : IDLE)
                  : state == BUSY ? (last ? DONE : BUSY)
                  : (bus.out_ready ? IDLE : DONE);
    end
    // residue is taken on the final sum only, as it is latched into out_an
    an_residue_mod u_res (.v(acc_nxt), .r(res));
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            sh    <= '0;
            cnt   <= '0;
            an_q  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.in_valid) begin
                sh  <= bus.in_n;
                acc <= '0;
                cnt <= '0;
            end else if (state == BUSY) begin
                acc <= acc_nxt;
                sh  <= sh >> 1;
                cnt <= cnt + 1'b1;
                if (last) begin
                    an_q  <= acc_nxt;
                    err_q <= res != '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_an_encoder_seq.sv
// tb_an_encoder_seq: directed and random scoreboard bench for the sequential AN encoder.
module tb_an_encoder_seq;
    import an_code_pkg::*;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   passed = 0;
    logic [AN_W-1:0] exp_q[$];
    an_encoder_seq_if bus();
    an_encoder_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // scoreboard: every completed output handshake pops one expected code word
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(bus.out_valid), 32'd0);
            end else begin
                check("out_an", 32'(bus.out_an), 32'(exp_q.pop_front()));
                check("out_res_err", 32'(bus.out_res_err), 32'd0);
            end
        end
    end

    task automatic send(input logic [N_W-1:0] n, input bit push);
        int t = 0;
        while (bus.in_ready !== 1'b1 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("in_ready_wait", 32'(t < 100), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_n = n;
        if (push) exp_q.push_back(AN_W'(n) * AN_W'(A));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_wait", 32'(t < 200), 32'd1);
    endtask

    initial begin
        logic [N_W-1:0] n;
        logic [AN_W-1:0] w, f;
        int t, seen;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_n = '0;
        bus.out_ready = 1'b0;
        #1;
        check("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_an", 32'(bus.out_an), 32'd0);
        check("rst_res_err", 32'(bus.out_res_err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        send('0, 1'b1);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);
        repeat (N_W - 1) @(posedge clk);
        #1;
        check("lat_n_minus_1", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_n", 32'(bus.out_valid), 32'd1);
        check("zero_an", 32'(bus.out_an), 32'd0);
        bus.out_ready = 1'b1;
        drain();

        send(23'd1, 1'b1);
        drain();
        check("one_an", 32'(bus.out_an), 32'h1D);
        send(23'd1312, 1'b1);
        drain();
        check("n1312_an", 32'(bus.out_an), 32'h94A0);
        send(23'h7FFFFF, 1'b1);
        drain();
        check("max_an", 32'(bus.out_an), 32'hE7FFFE3);

        bus.out_ready = 1'b0;
        send(23'd3, 1'b1);
        t = 0;
        while (bus.out_valid !== 1'b1 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("done_wait", 32'(t < 100), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_n = 23'd7;
        exp_q.push_back(AN_W'(7 * A));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_an", 32'(bus.out_an), 32'd87);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_not_busy", 32'(bus.busy), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_handoff_idle", 32'(bus.in_ready), 32'd1);
        check("bp_handoff_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_accept7", 32'(bus.busy), 32'd1);
        drain();
        check("seven_an", 32'(bus.out_an), 32'd203);

        send(23'd100, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_out_an", 32'(bus.out_an), 32'd0);
        check("abort_res_err", 32'(bus.out_res_err), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        check("abort_no_output", 32'(seen), 32'd0);
        send(23'd5, 1'b1);
        drain();
        check("five_an", 32'(bus.out_an), 32'd145);

        for (int i = 0; i < 2000; i++) begin
            n = N_W'($urandom);
            send(n, 1'b1);
            drain();
            if (i < 16) begin
                w = bus.out_an;
                seen = 0;
                for (int k = 0; k < AN_W; k++) begin
                    f = w ^ (AN_W'(1) << k);
                    if (f % AN_W'(A) == '0) seen++;
                    if ((f ^ (AN_W'(1) << k)) / AN_W'(A) != AN_W'(n)) seen++;
                end
                check("flip_detect", 32'(seen), 32'd0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
